// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
//   Data-memory controller between the multicycle CPU data port and a
//   word-wide single-port synchronous RAM without byte enables.
//   - Word stores go straight to the RAM.
//   - Byte/halfword stores are done as read-modify-write.
//   - Byte/halfword loads are right-aligned and zero-extended.
//   - Misaligned, out-of-range and reserved-format accesses are rejected
//     with addr_err alongside the ready pulse, without touching the RAM.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   data_addr  : CPU byte address
//   w_data     : CPU store data (low byte/half used for sub-word stores)
//   dmem_w     : store request, held until ready
//   dmem_r     : load request, held until ready (dmem_w wins if both high)
//   fmt        : 00 word, 01 halfword, 10 byte, 11 reserved
//   rdata      : right-aligned, zero-extended load data
//   ready      : one-cycle completion pulse
//   addr_err   : high with ready when the access was rejected
//   ram_addr   : RAM word address
//   ram_wdata  : RAM write data
//   ram_we     : RAM write strobe
//   ram_re     : RAM read strobe
//   ram_rdata  : RAM read data, valid the cycle after ram_re
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int          ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           w_data,
    input  logic                  dmem_w,
    input  logic                  dmem_r,
    input  logic [1:0]            fmt,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  addr_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [31:0]           ram_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] FMT_WORD = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_BYTE = 2'b10;

    logic [2:0]            r_state;
    logic [1:0]            r_fmt;
    logic [1:0]            r_lane;
    logic [31:0]           r_wdata;
    logic                  r_is_wr;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_addr_err;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [31:0]           r_ram_wdata;
    logic                  r_ram_we;
    logic                  r_ram_re;

    // Address decode on the live request (only used in IDLE).
    // The subtraction wraps, so addresses below the base land far above
    // the RAM size and fall out through the range check.
    logic [31:0]           w_offset;
    logic [1:0]            w_lane;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic                  w_range_err;
    logic                  w_err;
    logic                  w_req;

    assign w_offset    = data_addr - BASE_ADDR;
    assign w_lane      = w_offset[1:0];
    assign w_widx      = w_offset[ADDR_WIDTH+1:2];
    assign w_range_err = |w_offset[31:ADDR_WIDTH+2];
    assign w_req       = dmem_w | dmem_r;
    assign w_err       = w_range_err
                       || (fmt == 2'b11)
                       || (fmt == FMT_WORD && w_lane != 2'b00)
                       || (fmt == FMT_HALF && w_lane[0]);

    // Load alignment of the word returned by the RAM.
    logic [31:0] w_load_data;
    always_comb begin
        w_load_data = ram_rdata;
        case (r_fmt)
            FMT_BYTE: w_load_data = {24'b0, ram_rdata[8*r_lane +: 8]};
            FMT_HALF: w_load_data = r_lane[1] ? {16'b0, ram_rdata[31:16]}
                                              : {16'b0, ram_rdata[15:0]};
            default:  w_load_data = ram_rdata;
        endcase
    end

    // Per-lane merge for sub-word stores. A lane is replaced when it is the
    // addressed byte, or when it belongs to the addressed halfword; the upper
    // byte of a halfword takes w_data[15:8].
    logic [31:0] w_merge_data;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] LANE = 2'(gi);
            logic       w_hit;
            logic [7:0] w_src;
            assign w_hit = (r_fmt == FMT_BYTE && r_lane == LANE)
                        || (r_fmt == FMT_HALF && r_lane[1] == LANE[1]);
            assign w_src = (r_fmt == FMT_HALF && LANE[0]) ? r_wdata[15:8]
                                                         : r_wdata[7:0];
            assign w_merge_data[8*gi +: 8] = w_hit ? w_src : ram_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fmt       <= 2'b00;
            r_lane      <= 2'b00;
            r_wdata     <= 32'b0;
            r_is_wr     <= 1'b0;
            r_rdata     <= 32'b0;
            r_ready     <= 1'b0;
            r_addr_err  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 32'b0;
            r_ram_we    <= 1'b0;
            r_ram_re    <= 1'b0;
        end else begin
            // Strobes and status are single-cycle pulses by default.
            r_ready    <= 1'b0;
            r_addr_err <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_wr <= dmem_w;
                        r_fmt   <= fmt;
                        r_lane  <= w_lane;
                        r_wdata <= w_data;
                        if (w_err) begin
                            r_addr_err <= 1'b1;
                            r_ready    <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_ram_addr <= w_widx;
                            if (dmem_w && fmt == FMT_WORD) begin
                                r_ram_we    <= 1'b1;
                                r_ram_wdata <= w_data;
                                r_state     <= S_WR;
                            end else begin
                                // Loads and sub-word stores both start with a read.
                                r_ram_re <= 1'b1;
                                r_state  <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_is_wr) begin
                        r_ram_wdata <= w_merge_data;
                        r_ram_we    <= 1'b1;
                        r_state     <= S_WR;
                    end else begin
                        r_rdata <= w_load_data;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_WR: begin
                    r_ready <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign ready     = r_ready;
    assign addr_err  = r_addr_err;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign ram_re    = r_ram_re;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
//   Self-checking bench for dmem_ctrl with a behavioural synchronous RAM.
//   Each access pushes its expected outcome onto a scoreboard queue when it
//   is driven; the entry is popped and compared when ready is observed.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int          AW   = 11;
    localparam logic [31:0] BASE = 32'h1001_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_clr = 1'b1;
    logic [31:0]   data_addr = '0;
    logic [31:0]   w_data = '0;
    logic          dmem_w = 1'b0;
    logic          dmem_r = 1'b0;
    logic [1:0]    fmt = 2'b00;
    logic [31:0]   rdata;
    logic          ready;
    logic          addr_err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata = '0;

    dmem_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_addr (data_addr),
        .w_data    (w_data),
        .dmem_w    (dmem_w),
        .dmem_r    (dmem_r),
        .fmt       (fmt),
        .rdata     (rdata),
        .ready     (ready),
        .addr_err  (addr_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on ram_we, read data valid the cycle after ram_re.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'b0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    // Count every write strobe the RAM sees (used by the reset test).
    int we_total = 0;
    always @(negedge clk) if (ram_we) we_total++;

    typedef struct {
        logic        err;
        int          lat;
        logic [31:0] rd;
        int          nwe;
        int          nre;
        int          wecyc;
        logic [31:0] weaddr;
        logic [31:0] wedata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] ref_rdata = '0;
    logic [31:0] last_we_data = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic run_acc(input logic iw, input logic ir, input logic [31:0] a,
                           input logic [1:0] f, input logic [31:0] wd);
        exp_t        e;
        exp_t        g;
        logic [31:0] off;
        logic [31:0] old;
        logic [31:0] mask;
        logic [1:0]  ln;
        int          sh;
        int          cyc;
        int          nwe;
        int          nre;
        int          wecyc;
        logic [31:0] weaddr;
        logic        both;

        off  = a - BASE;
        ln   = off[1:0];
        sh   = 8 * int'(ln);
        old  = ref_mem[off[12:2]];
        e.err = (off >= 32'd8192) || (f == 2'b11) || (f == 2'b00 && ln != 2'b00)
             || (f == 2'b01 && ln[0]);
        e.nwe = 0; e.nre = 0; e.wecyc = 0; e.weaddr = '0; e.wedata = '0;
        e.rd  = ref_rdata;
        if (e.err) begin
            e.lat = 1;
        end else if (iw) begin
            e.nwe    = 1;
            e.weaddr = {21'b0, off[12:2]};
            if (f == 2'b00) begin
                e.lat = 2; e.wecyc = 1; e.wedata = wd;
            end else begin
                mask     = (f == 2'b10) ? 32'h0000_00FF : 32'h0000_FFFF;
                e.wedata = (old & ~(mask << sh)) | ((wd & mask) << sh);
                e.lat = 4; e.nre = 1; e.wecyc = 3;
            end
            ref_mem[off[12:2]] = e.wedata;
        end else begin
            mask = (f == 2'b00) ? 32'hFFFF_FFFF : (f == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
            e.rd  = (old >> sh) & mask;
            e.lat = 3; e.nre = 1;
            ref_rdata = e.rd;
        end
        sb.push_back(e);

        @(negedge clk);
        dmem_w = iw; dmem_r = ir; fmt = f; data_addr = a; w_data = wd;
        cyc = 0; nwe = 0; nre = 0; wecyc = 0; weaddr = '0; both = 1'b0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            // Scramble address/data/format after accept; the DUT must ignore it.
            if (cyc == 1) begin
                data_addr = $urandom; w_data = $urandom; fmt = 2'($urandom_range(0, 3));
            end
            if (ram_we) begin
                nwe++; wecyc = cyc; weaddr = 32'(ram_addr); last_we_data = ram_wdata;
            end
            if (ram_re) nre++;
            if (ram_we && ram_re) both = 1'b1;
            if (ready || cyc >= 12) break;
        end
        dmem_w = 1'b0; dmem_r = 1'b0;

        g = sb.pop_front();
        chk("latency", cyc, g.lat);
        chk("addr_err", {31'b0, addr_err}, {31'b0, g.err});
        chk("rdata", rdata, g.rd);
        chk("n_we", nwe, g.nwe);
        chk("n_re", nre, g.nre);
        chk("we_re_excl", {31'b0, both}, 32'd0);
        if (g.nwe != 0) begin
            chk("we_cycle", wecyc, g.wecyc);
            chk("we_addr", weaddr, g.weaddr);
            chk("we_data", last_we_data, g.wedata);
        end
        $display("txn w=%0b r=%0b addr=%08h fmt=%0d wd=%08h lat=%0d err=%0b rdata=%08h",
                 iw, ir, a, f, wd, cyc, addr_err, rdata);
        @(posedge clk); #1;
        chk("ready_pulse", {31'b0, ready}, 32'd0);
    endtask

    initial begin
        int we_before;
        logic [31:0] ra;
        logic [1:0]  rf;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ctl", {28'b0, ready, addr_err, ram_we, ram_re}, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk);

        // Directed sequence.
        run_acc(1'b1, 1'b0, 32'h1001_0004, 2'b00, 32'hDEAD_BEEF);
        chk("plan_word_store", last_we_data, 32'hDEAD_BEEF);
        run_acc(1'b0, 1'b1, 32'h1001_0006, 2'b10, 32'h0);
        chk("plan_byte_load", rdata, 32'h0000_00AD);
        run_acc(1'b1, 1'b0, 32'h1001_0005, 2'b10, 32'h1234_5677);
        chk("plan_byte_store", last_we_data, 32'hDEAD_77EF);
        run_acc(1'b1, 1'b0, 32'h1001_0006, 2'b01, 32'h0000_CAFE);
        chk("plan_half_store", last_we_data, 32'hCAFE_77EF);
        run_acc(1'b0, 1'b1, 32'h1001_0006, 2'b01, 32'h0);
        chk("plan_half_load", rdata, 32'h0000_CAFE);

        // Rejected accesses.
        run_acc(1'b0, 1'b1, 32'h1001_0005, 2'b01, 32'h0);
        run_acc(1'b1, 1'b0, 32'h1000_FFFC, 2'b00, 32'h1111_1111);
        run_acc(1'b0, 1'b1, 32'h1001_0004, 2'b11, 32'h0);
        run_acc(1'b1, 1'b0, 32'h1001_0004, 2'b11, 32'h2222_2222);
        run_acc(1'b1, 1'b0, 32'h1001_2000, 2'b00, 32'h3333_3333);
        run_acc(1'b0, 1'b1, 32'h1001_0002, 2'b00, 32'h0);
        chk("err_rdata_kept", rdata, 32'h0000_CAFE);

        // Range boundary: last word is fine; store wins when both requested.
        run_acc(1'b1, 1'b0, 32'h1001_1FFC, 2'b00, 32'hA5A5_5A5A);
        run_acc(1'b0, 1'b1, 32'h1001_1FFF, 2'b10, 32'h0);
        run_acc(1'b1, 1'b1, 32'h1001_0008, 2'b00, 32'h1111_2222);
        run_acc(1'b0, 1'b1, 32'h1001_0008, 2'b00, 32'h0);

        // Reset while in RD of a byte store.
        @(negedge clk);
        dmem_w = 1'b1; fmt = 2'b10; data_addr = 32'h1001_0005; w_data = 32'h0000_0055;
        @(posedge clk); #1;
        chk("rst_mid_in_rd", {31'b0, ram_re}, 32'd1);
        we_before = we_total;
        rst = 1'b1;
        #1;
        dmem_w = 1'b0;
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_ctl", {28'b0, ready, addr_err, ram_we, ram_re}, 32'd0);
        chk("rst_mid_ram_addr", 32'(ram_addr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = 32'd0;
        @(posedge clk);
        chk("rst_mid_no_we", we_total, we_before);
        run_acc(1'b0, 1'b1, 32'h1001_0004, 2'b00, 32'h0);
        chk("rst_mid_word1", rdata, 32'hCAFE_77EF);

        // Random mix over the first few words plus occasional bad addresses.
        for (int n = 0; n < 40; n++) begin
            ra = BASE + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) ra = BASE - 32'($urandom_range(1, 16));
            rf = 2'($urandom_range(0, 3));
            if (rf == 2'b11 && $urandom_range(0, 3) != 0) rf = 2'b10;
            if (rf == 2'b00) ra[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            if ($urandom_range(0, 1) == 1)
                run_acc(1'b1, 1'b0, ra, rf, $urandom);
            else
                run_acc(1'b0, 1'b1, ra, rf, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller that sits directly downstream of the multicycle CPU's data port. It takes the CPU's byte address, store data, read/write strobes and access format, and drives a word-wide, single-port synchronous RAM that has no byte enables. It right-aligns byte and halfword loads, and performs read-modify-write for byte and halfword stores. It returns a one-cycle ready pulse, and flags misaligned, out-of-range or reserved-format accesses.

Parameters:
ADDR_WIDTH, 11, RAM word-address bits (RAM depth = 2^ADDR_WIDTH words)
BASE_ADDR, 32'h1001_0000, CPU byte address that maps to RAM word 0

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
data_addr  input  32  CPU byte address
w_data  input  32  CPU store data; the low byte or low halfword is used for sub-word stores
dmem_w  input  1  store request; held until ready
dmem_r  input  1  load request; held until ready
fmt  input  2  access format: 00 word, 01 halfword, 10 byte, 11 reserved
rdata  output  32  right-aligned, zero-extended load data
ready  output  1  one-cycle pulse marking completion of the current access
addr_err  output  1  asserted together with ready when the access was rejected
ram_addr  output  ADDR_WIDTH  RAM word address
ram_wdata  output  32  RAM write data
ram_we  output  1  RAM write strobe
ram_re  output  1  RAM read strobe
ram_rdata  input  32  RAM read data, valid the cycle after ram_re

Behaviour:
- Reset (asynchronous, active-high) state: FSM is IDLE; rdata, ready, addr_err, ram_addr, ram_wdata, ram_we and ram_re are all 0.
- All outputs are registered.
- Reset mid-operation: abort immediately and return to IDLE. No RAM write is issued unless the FSM had already reached WR.
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - Samples dmem_w and dmem_r. If both are high, dmem_w wins.
  - On accept, latch data_addr, fmt and w_data. Compute offset = data_addr - BASE_ADDR (32-bit unsigned, wrapping). Word index = offset[ADDR_WIDTH+1:2]; byte lane = offset[1:0].
- Error check at accept. The access is an error if any of the following holds:
  - offset >= 4*2^ADDR_WIDTH (this also catches addresses below BASE_ADDR through the wrap);
  - fmt = 11;
  - fmt = 00 and lane != 0;
  - fmt = 01 and lane[0] = 1.
  On error: go straight to DONE with addr_err = 1 and no RAM strobe. rdata is left unchanged.
- Word store: IDLE -> WR (ram_we = 1, ram_wdata = w_data) -> DONE. ready is high 2 cycles after accept.
- Load: IDLE -> RD (ram_re = 1) -> WAIT (capture ram_rdata and align into rdata) -> DONE. ready is high 3 cycles after accept.
  - Byte load: rdata = {24'b0, byte at lane}.
  - Halfword load: rdata = {16'b0, half selected by lane[1]}.
  - Lanes are little-endian: lane 0 = bits 7:0.
- Sub-word store: IDLE -> RD -> WAIT (merge) -> WR -> DONE. ready is high 4 cycles after accept.
  - Byte merge: replace lane k of the old word with w_data[7:0].
  - Halfword merge: replace bits [31:16] if lane[1] = 1, otherwise bits [15:0], with w_data[15:0]; all other bits are kept.
- DONE: ready = 1 for exactly one cycle. Requests are ignored in this cycle. Next state is IDLE.
- The CPU must drop its request in the cycle it sees ready. A request still high in IDLE is treated as a new access.
- ram_addr holds the latched word index from RD/WR onward. ram_we and ram_re are never high in the same cycle.
- rdata holds its value until the next successful load. Stores never change rdata.
- Changes on the input request signals after accept are ignored until DONE.

Test Plan:
- Word store: data_addr = 0x10010004, w_data = 0xDEADBEEF, dmem_w = 1, fmt = 00 -> one cycle after accept ram_we = 1, ram_addr = 1, ram_wdata = 0xDEADBEEF; ready pulses 2 cycles after accept, addr_err = 0.
- Byte load: then load byte at 0x10010006 -> ram_re = 1 one cycle after accept; rdata = 0x000000AD; ready pulses 3 cycles after accept.
- Byte store (RMW): store byte at 0x10010005 with w_data = 0x12345677 -> one RAM read, then ram_we with ram_wdata = 0xDEAD77EF; ready pulses 4 cycles after accept.
- Halfword store and load: store half at 0x10010006 with w_data = 0x0000CAFE -> RAM word 1 = 0xCAFE77EF. A subsequent halfword load at 0x10010006 -> rdata = 0x0000CAFE.
- Error cases, each expecting ready = 1 and addr_err = 1 one cycle after accept, with no ram_re or ram_we and rdata unchanged:
  - halfword load at 0x10010005 (misaligned);
  - word store at 0x1000FFFC (below base);
  - any access with fmt = 11.
- Reset mid-operation: assert rst while in RD of a byte store -> all outputs 0 immediately, no ram_we ever issued, FSM in IDLE. The next word load of 0x10010004 returns 0xCAFE77EF.
